ntt_engine: RTL

Parametrised in-place number-theoretic transform engine, the successor to the fixed 256-point forward-only NTT core. It supports both forward transform (Cooley-Tukey) and inverse transform (Gentleman-Sande, including N⁻¹ scaling), with valid/ready handshakes on input and output. It sits between the polynomial coefficient stream and the pointwise-multiply stage, and reads twiddles from an external asynchronous ROM.

---
 rtl/ntt_pkg.sv | 36 +++
 rtl/ntt_bu.sv | 37 +++
 rtl/ntt_engine.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ntt_pkg.sv
// Shared constants, FSM state type and modular arithmetic helpers for the NTT engine.
package ntt_pkg;

  localparam int DEF_N    = 256;
  localparam int DEF_W    = 23;
  localparam int DEF_Q    = 8380417;
  localparam int DEF_NINV = 8347681;

  // Helpers work on a fixed 32-bit word; callers zero-extend W-bit values into it.
  localparam int FW = 32;
  typedef logic [FW-1:0] word_t;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_COMPUTE,
    ST_UNLOAD
  } state_t;

  function automatic word_t mod_add(word_t a, word_t b, word_t q);
    logic [FW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, q}) s = s - {1'b0, q};
    return word_t'(s);
  endfunction

  function automatic word_t mod_sub(word_t a, word_t b, word_t q);
    return (a >= b) ? (a - b) : (a + q - b);
  endfunction

  function automatic word_t mod_mul(word_t a, word_t b, word_t q);
    logic [2*FW-1:0] p;
    p = {{FW{1'b0}}, a} * {{FW{1'b0}}, b};
    return word_t'(p % {{FW{1'b0}}, q});
  endfunction

endpackage

// File: rtl/ntt_bu.sv
// Combinational butterfly: Cooley-Tukey when inv = 0, Gentleman-Sande when inv = 1.
module ntt_bu
  import ntt_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int Q = DEF_Q
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] tf,
  input  logic         inv,
  output logic [W-1:0] a,
  output logic [W-1:0] b
);

  localparam word_t QW = word_t'(Q);

  word_t xw, yw, tw, t, d, ntf;

  // Both butterfly flavours share the operands; the mode picks which results leave.
  always_comb begin
    xw  = word_t'(x);
    yw  = word_t'(y);
    tw  = word_t'(tf);
    t   = mod_mul(tw, yw, QW);
    d   = mod_sub(xw, yw, QW);
    ntf = (tw == '0) ? '0 : (QW - tw);
    if (inv) begin
      a = W'(mod_add(xw, yw, QW));
      b = W'(mod_mul(ntf, d, QW));
    end else begin
      a = W'(mod_add(xw, t, QW));
      b = W'(mod_sub(xw, t, QW));
    end
  end

endmodule

// File: rtl/ntt_engine.sv
// In-place forward/inverse NTT: load N words, one butterfly per cycle, then stream out.
module ntt_engine
  import ntt_pkg::*;
#(
  parameter int N    = DEF_N,
  parameter int W    = DEF_W,
  parameter int Q    = DEF_Q,
  parameter int NINV = DEF_NINV,
  localparam int LOGN = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_data,
  input  logic            in_inv,
  output logic [LOGN-1:0] tf_addr,
  input  logic [W-1:0]    tf_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_data,
  output logic            busy
);

  localparam int SW = (LOGN > 1) ? $clog2(LOGN) : 1;
  localparam int BW = LOGN - 1;
  localparam word_t QW    = word_t'(Q);
  localparam word_t NINVW = word_t'(NINV);
  localparam logic [SW-1:0]   LAST_STAGE = SW'(LOGN - 1);
  localparam logic [BW-1:0]   LAST_BFLY  = '1;
  localparam logic [LOGN-1:0] ONE        = LOGN'(1);
  localparam logic [LOGN:0]   N_FULL     = {1'b1, {LOGN{1'b0}}};

  state_t          state;
  logic [W-1:0]    mem [N];
  logic [LOGN-1:0] icnt;
  logic [SW-1:0]   stage;
  logic [BW-1:0]   bcnt;
  logic [LOGN:0]   ocnt;
  logic            inv;

  logic [SW-1:0]   lg;
  logic [LOGN-1:0] b_ext, low_mask, idx_x, idx_y, grp, k_fwd, k_inv, out_idx;
  logic [W-1:0]    bu_a, bu_b, out_word;

  assign in_ready = (state == ST_LOAD);

  // Map the flat butterfly counter to the pair (j, j+len) by inserting a zero bit at log2(len).
  always_comb begin
    lg       = inv ? stage : (LAST_STAGE - stage);
    b_ext    = {1'b0, bcnt};
    low_mask = (ONE << lg) - ONE;
    idx_x    = ((b_ext & ~low_mask) << 1) | (b_ext & low_mask);
    idx_y    = idx_x | (ONE << lg);
    grp      = b_ext >> lg;
    k_fwd    = (ONE << stage) + grp;
    k_inv    = LOGN'((N_FULL >> stage) - {1'b0, ONE} - {1'b0, grp});
    tf_addr  = (state == ST_COMPUTE) ? (inv ? k_inv : k_fwd) : ONE;
  end

  // Output word fetch; the first word is taken while the final butterfly runs (it never touches index 0).
  always_comb begin
    out_idx  = (state == ST_COMPUTE) ? '0 : ocnt[LOGN-1:0];
    out_word = inv ? W'(mod_mul(word_t'(mem[out_idx]), NINVW, QW)) : mem[out_idx];
  end

  ntt_bu #(.W(W), .Q(Q)) u_bu (
    .x  (mem[idx_x]),
    .y  (mem[idx_y]),
    .tf (tf_data),
    .inv(inv),
    .a  (bu_a),
    .b  (bu_b)
  );

  // Frame FSM: load, in-place butterflies, registered output stream.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_LOAD;
      icnt      <= '0;
      stage     <= '0;
      bcnt      <= '0;
      ocnt      <= '0;
      inv       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (in_valid) begin
            mem[icnt] <= in_data;
            if (icnt == '0) inv <= in_inv;
            icnt <= icnt + ONE;
            if (icnt == '1) begin
              state <= ST_COMPUTE;
              busy  <= 1'b1;
              stage <= '0;
              bcnt  <= '0;
            end
          end
        end
        ST_COMPUTE: begin
          mem[idx_x] <= bu_a;
          mem[idx_y] <= bu_b;
          bcnt       <= bcnt + 1'b1;
          if (bcnt == LAST_BFLY) begin
            stage <= stage + 1'b1;
            if (stage == LAST_STAGE) begin
              stage     <= '0;
              state     <= ST_UNLOAD;
              out_data  <= out_word;
              out_valid <= 1'b1;
              ocnt      <= {{LOGN{1'b0}}, 1'b1};
            end
          end
        end
        ST_UNLOAD: begin
          if (!out_valid || out_ready) begin
            if (ocnt == N_FULL) begin
              out_valid <= 1'b0;
              busy      <= 1'b0;
              ocnt      <= '0;
              state     <= ST_LOAD;
            end else begin
              out_data  <= out_word;
              out_valid <= 1'b1;
              ocnt      <= ocnt + 1'b1;
            end
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule
